// File: rtl/ctr_n_dyn_tr.sv
// ctr_n_dyn_tr: time-redundant phase counter with recovery and halt control.
// Optional CTR_PHASE_TMR_EN triplicates the phase counter with majority voting.
module ctr_n_dyn_tr #(
  parameter int PHASES  = 3,
  parameter int MW      = 2,
  parameter int REC_LEN = 4,
  parameter int FAIL_TH = 3,
  localparam int CW = (PHASES > 1) ? $clog2(PHASES) : 1,
  localparam int FW = (FAIL_TH > 0) ? $clog2(FAIL_TH + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fail,
  input  logic [MW-1:0] userMode,
  input  logic          clrFail,
  output logic [MW-1:0] modeS,
  output logic [CW-1:0] ctr,
  output logic          errFlag,
  output logic          userFail,
  output logic [FW-1:0] failCnt,
  output logic          ctrMis
);

  localparam int RW = $clog2(REC_LEN + 1);
  localparam logic [RW-1:0] REC_LOAD = RW'(REC_LEN - 1);
  localparam logic [CW-1:0] CTR_LAST = CW'(PHASES - 1);
  localparam logic [FW-1:0] CNT_MAX  = FW'(FAIL_TH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REC,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [MW-1:0] r_mode;
  logic [MW-1:0] w_mode_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          r_uf;
  logic          w_uf_nxt;
  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_fcnt_nxt;
  logic [FW-1:0] w_fcnt_inc;
  logic [FW-1:0] w_fcnt_hit;
  logic [RW-1:0] r_rec;
  logic [RW-1:0] w_rec_nxt;
  logic [CW-1:0] w_ctr;
  logic [CW-1:0] w_ctr_nxt;
  logic          w_wrap;

  assign w_wrap     = (w_ctr == CTR_LAST);
  assign w_fcnt_inc = (r_fcnt == CNT_MAX) ? r_fcnt
                                          : r_fcnt + FW'(1);
  assign w_fcnt_hit = clrFail ? FW'(1) : w_fcnt_inc;

`ifdef CTR_PHASE_TMR_EN
  logic [CW-1:0] r_ctr_a;
  logic [CW-1:0] r_ctr_b;
  logic [CW-1:0] r_ctr_c;

  assign w_ctr = (r_ctr_a & r_ctr_b)
               | (r_ctr_a & r_ctr_c)
               | (r_ctr_b & r_ctr_c);
  assign ctrMis = (r_ctr_a != r_ctr_b)
               || (r_ctr_a != r_ctr_c);

  // All three copies reload from the voted next value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctr_a <= '0;
      r_ctr_b <= '0;
      r_ctr_c <= '0;
    end else begin
      r_ctr_a <= w_ctr_nxt;
      r_ctr_b <= w_ctr_nxt;
      r_ctr_c <= w_ctr_nxt;
    end
  end
`else
  logic [CW-1:0] r_ctr;

  assign w_ctr  = r_ctr;
  assign ctrMis = 1'b0;

  // Single phase counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctr <= '0;
    end else begin
      r_ctr <= w_ctr_nxt;
    end
  end
`endif

  // Control state and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_err   <= 1'b0;
      r_uf    <= 1'b0;
      r_fcnt  <= '0;
      r_rec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_err   <= w_err_nxt;
      r_uf    <= w_uf_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_rec   <= w_rec_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_err_nxt   = r_err;
    w_uf_nxt    = r_uf;
    w_fcnt_nxt  = clrFail ? '0 : r_fcnt;
    w_rec_nxt   = r_rec;
    w_ctr_nxt   = w_ctr;
    unique case (r_state)
      S_IDLE: begin
        w_ctr_nxt  = '0;
        w_err_nxt  = 1'b0;
        w_mode_nxt = userMode;
        if (userMode != '0) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (fail) begin
          w_ctr_nxt  = '0;
          w_err_nxt  = 1'b1;
          w_fcnt_nxt = w_fcnt_hit;
          if (w_fcnt_hit == CNT_MAX) begin
            w_state_nxt = S_HALT;
            w_uf_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_REC;
            w_rec_nxt   = REC_LOAD;
          end
        end else if (w_wrap) begin
          w_ctr_nxt  = '0;
          w_mode_nxt = userMode;
          if (userMode == '0) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_ctr_nxt = w_ctr + CW'(1);
        end
      end
      S_REC: begin
        w_ctr_nxt = '0;
        if (fail) begin
          w_rec_nxt = REC_LOAD;
        end else if (r_rec == '0) begin
          w_state_nxt = S_RUN;
          w_err_nxt   = 1'b0;
        end else begin
          w_rec_nxt = r_rec - RW'(1);
        end
      end
      S_HALT: begin
        w_fcnt_nxt = r_fcnt;
        if (clrFail) begin
          w_state_nxt = S_IDLE;
          w_mode_nxt  = '0;
          w_fcnt_nxt  = '0;
          w_uf_nxt    = 1'b0;
          w_err_nxt   = 1'b0;
          w_ctr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign modeS    = r_mode;
  assign ctr      = w_ctr;
  assign errFlag  = r_err;
  assign userFail = r_uf;
  assign failCnt  = r_fcnt;

endmodule
